// File: rtl/addsub_acc_pipe.sv
// Registered add/subtract unit with carry, signed overflow, sticky overflow and accumulator.
// Optional output saturation on signed overflow when ADDSUB_ACC_SAT_EN is defined.
module addsub_acc_pipe #(
    parameter int WIDTH = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VLD,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             CLR,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OFL,
    output logic             OFL_STKY,
    output logic             OUT_VLD
);

    localparam int MSB = WIDTH - 1;
`ifdef ADDSUB_ACC_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH:0]   sum_s;
    logic             is_add_s;
    logic             ofl_s;
    logic [WIDTH-1:0] res_s;

    // Operand selection, WIDTH+1-bit sum and signed overflow detection
    always_comb begin
        x_s      = '0;
        y_s      = '0;
        sum_s    = '0;
        is_add_s = 1'b0;
        ofl_s    = 1'b0;
        // OP 01 and 10 add, OP 00 and 11 subtract; a same-cycle CLR zeroes the accumulator operand
        is_add_s = OP[0] ^ OP[1];
        if (OP[1]) begin
            x_s = CLR ? '0 : acc_r;
        end else begin
            x_s = A;
        end
        y_s   = is_add_s ? B : ~B;
        sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, CI};
        ofl_s = (x_s[MSB] == y_s[MSB]) && (sum_s[MSB] != x_s[MSB]);
    end

    // Final result: clamped on overflow when saturation is built in, otherwise wrapped
    always_comb begin
        res_s = '0;
`ifdef ADDSUB_ACC_SAT_EN
        if (ofl_s) begin
            res_s = x_s[MSB] ? SMIN : SMAX;
        end else begin
            res_s = sum_s[MSB:0];
        end
`else
        res_s = sum_s[MSB:0];
`endif
    end

    // Output registers, sticky flag and accumulator
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            S        <= '0;
            CO       <= 1'b0;
            OFL      <= 1'b0;
            OFL_STKY <= 1'b0;
            OUT_VLD  <= 1'b0;
            acc_r    <= '0;
        end else begin
            if (IN_VLD) begin
                S        <= res_s;
                CO       <= sum_s[WIDTH];
                OFL      <= ofl_s;
                OUT_VLD  <= 1'b1;
                OFL_STKY <= (OFL_STKY & ~CLR) | ofl_s;
            end else begin
                OUT_VLD  <= 1'b0;
                OFL_STKY <= OFL_STKY & ~CLR;
            end
            if (IN_VLD && OP[1]) begin
                acc_r <= res_s;
            end else if (CLR) begin
                acc_r <= '0;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Self-checking bench for addsub_acc_pipe: directed scenarios plus randomized ops
// against an integer-arithmetic reference model.
module tb_addsub_acc_pipe;

    localparam int W    = 9;
    localparam int MOD  = 512;
    localparam int HALF = 256;
`ifdef ADDSUB_ACC_SAT_EN
    localparam logic [W-1:0] T2_S = 9'h0FF;
    localparam logic [W-1:0] T3_S = 9'h0FF;
`else
    localparam logic [W-1:0] T2_S = 9'h100;
    localparam logic [W-1:0] T3_S = 9'h12C;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         IN_VLD = 1'b0;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CI = 1'b0;
    logic         CLR = 1'b0;
    logic [W-1:0] S;
    logic         CO, OFL, OFL_STKY, OUT_VLD;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int           m_acc = 0;
    bit           m_stky = 1'b0;
    logic [W-1:0] m_s = '0;
    bit           m_co = 1'b0;
    bit           m_ofl = 1'b0;
    bit           m_vld = 1'b0;

    logic [W+3:0] got;
    logic [W+3:0] exp_v;

    addsub_acc_pipe #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .OP(OP), .A(A), .B(B), .CI(CI),
        .CLR(CLR), .S(S), .CO(CO), .OFL(OFL), .OFL_STKY(OFL_STKY), .OUT_VLD(OUT_VLD)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W+3:0] outs();
        return {S, CO, OFL, OFL_STKY, OUT_VLD};
    endfunction

    function automatic logic [W+3:0] model_outs();
        return {m_s, m_co, m_ofl, m_stky, m_vld};
    endfunction

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - MOD : v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_stky = 1'b0; m_s = '0; m_co = 1'b0; m_ofl = 1'b0; m_vld = 1'b0;
    endtask

    // Drive one cycle's inputs, advance past the edge, update the reference model.
    task automatic cycle(input bit vld, input bit [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit ci, input bit clr);
        int  x, y, raw, tr, res;
        bit  add, ofl;
        IN_VLD = vld; OP = op; A = a; B = b; CI = ci; CLR = clr;
        @(posedge CLK);
        if (vld) begin
            x   = op[1] ? (clr ? 0 : m_acc) : int'(a);
            add = (op == 2'b01) || (op == 2'b10);
            y   = add ? int'(b) : (MOD - 1 - int'(b));
            raw = x + y + int'(ci);
            tr  = to_signed(x) + to_signed(y) + int'(ci);
            ofl = (tr > HALF - 1) || (tr < -HALF);
            res = raw % MOD;
`ifdef ADDSUB_ACC_SAT_EN
            if (ofl) res = (tr > 0) ? HALF - 1 : HALF;
`endif
            m_s    = res[W-1:0];
            m_co   = (raw >= MOD);
            m_ofl  = ofl;
            m_vld  = 1'b1;
            m_stky = (clr ? 1'b0 : m_stky) | ofl;
            if (op[1]) m_acc = res;
            else if (clr) m_acc = 0;
        end else begin
            m_vld = 1'b0;
            if (clr) begin
                m_acc  = 0;
                m_stky = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; got = outs();
        if (got !== '0) begin
            n_fail++; $display("FAIL reset_state {S,CO,OFL,STKY,VLD} got=%h want=0", got);
        end
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_sub_add();
        cycle(1'b1, 2'b00, 9'd5, 9'd9, 1'b1, 1'b0);
        n_checks++; got = outs(); exp_v = {9'h1FC, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL sub_5_9 got=%h want=%h", got, exp_v); end
        cycle(1'b0, 2'b00, 9'd0, 9'd0, 1'b0, 1'b0);
        n_checks++; got = outs(); exp_v = {9'h1FC, 1'b0, 1'b0, 1'b0, 1'b0};
        if (got !== exp_v) begin n_fail++; $display("FAIL vld_pulse got=%h want=%h", got, exp_v); end
        cycle(1'b1, 2'b01, 9'h0FF, 9'h001, 1'b0, 1'b0);
        n_checks++; got = outs(); exp_v = {T2_S, 1'b0, 1'b1, 1'b1, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL add_ovf got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_back_to_back_acc();
        logic [W-1:0] want_s [3];
        bit           want_o [3];
        want_s[0] = 9'd100; want_s[1] = 9'd200; want_s[2] = T3_S;
        want_o[0] = 1'b0;   want_o[1] = 1'b0;   want_o[2] = 1'b1;
        cycle(1'b0, 2'b00, 9'd0, 9'd0, 1'b0, 1'b1);
        n_checks++; got = outs(); exp_v = {T2_S, 1'b0, 1'b1, 1'b0, 1'b0};
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_only got=%h want=%h", got, exp_v); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'b10, 9'd0, 9'd100, 1'b0, 1'b0);
            n_checks++; got = outs(); exp_v = {want_s[i], 1'b0, want_o[i], want_o[i], 1'b1};
            if (got !== exp_v) begin n_fail++; $display("FAIL acc_step%0d got=%h want=%h", i, got, exp_v); end
        end
        cycle(1'b1, 2'b10, 9'd0, 9'd0, 1'b0, 1'b0);
        n_checks++; got = outs(); exp_v = {T3_S, 1'b0, 1'b0, 1'b1, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL acc_read3 got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_acc_sub_clr();
        cycle(1'b1, 2'b10, 9'd0, 9'd50, 1'b0, 1'b1);
        n_checks++; got = outs(); exp_v = {9'd50, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_load50 got=%h want=%h", got, exp_v); end
        cycle(1'b1, 2'b11, 9'd0, 9'd60, 1'b1, 1'b0);
        n_checks++; got = outs(); exp_v = {9'h1F6, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL acc_sub60 got=%h want=%h", got, exp_v); end
        cycle(1'b1, 2'b10, 9'd0, 9'd7, 1'b0, 1'b1);
        n_checks++; got = outs(); exp_v = {9'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL clr_add7 got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'b01, 9'h1AA, 9'h055, 1'b1, 1'b0);
            n_checks++; got = outs(); exp_v = {9'd7, 1'b0, 1'b0, 1'b0, 1'b0};
            if (got !== exp_v) begin n_fail++; $display("FAIL idle_hold%0d got=%h want=%h", i, got, exp_v); end
        end
        cycle(1'b1, 2'b10, 9'd0, 9'd0, 1'b0, 1'b0);
        n_checks++; got = outs(); exp_v = {9'd7, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL idle_acc got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 2'b10, 9'd0, 9'd123, 1'b0, 1'b1);
        n_checks++; got = outs(); exp_v = {9'd123, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL pre_reset got=%h want=%h", got, exp_v); end
        IN_VLD = 1'b1; OP = 2'b01; A = 9'd1; B = 9'd1; CI = 1'b0; CLR = 1'b0;
        #2 RST = 1'b1;
        #1;
        n_checks++; got = outs();
        if (got !== '0) begin n_fail++; $display("FAIL async_reset got=%h want=0", got); end
        @(posedge CLK);
        #1 RST = 1'b0; IN_VLD = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 2'b01, 9'd1, 9'd1, 1'b0, 1'b0);
            n_checks++; got = outs();
            if (got !== '0) begin n_fail++; $display("FAIL post_reset%0d got=%h want=0", i, got); end
        end
        cycle(1'b1, 2'b10, 9'd0, 9'd0, 1'b0, 1'b0);
        n_checks++; got = outs(); exp_v = {9'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        if (got !== exp_v) begin n_fail++; $display("FAIL reset_acc got=%h want=%h", got, exp_v); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  9'($urandom_range(0, MOD - 1)), 9'($urandom_range(0, MOD - 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
            n_checks++; got = outs(); exp_v = model_outs();
            if (got !== exp_v) begin
                n_fail++; $display("FAIL random%0d {S,CO,OFL,STKY,VLD} got=%h want=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sub_add();
        test_back_to_back_acc();
        test_acc_sub_clr();
        test_idle_hold();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
